// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that shares one UART transmitter among
// NUM_REQ byte requesters, with a watchdog that aborts transfers lacking a done pulse.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned TIMEOUT_CLKS = 4096
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst,
  input  logic [NUM_REQ-1:0]   i_Req,
  input  logic [8*NUM_REQ-1:0] i_Req_Byte,
  output logic [NUM_REQ-1:0]   o_Grant,
  output logic [NUM_REQ-1:0]   o_Ack,
  output logic                 o_Timeout,
  output logic                 o_Busy,
  output logic                 o_TX_DV,
  output logic [7:0]           o_TX_Byte,
  input  logic                 i_TX_Active,
  input  logic                 i_TX_Done
);

  localparam int unsigned      PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned      WD_W    = $clog2(TIMEOUT_CLKS) + 1;
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CLKS - 1);
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q;
  logic [PTR_W-1:0]   owner_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [NUM_REQ-1:0] ack_q;
  logic               timeout_q;
  logic [7:0]         byte_q;
  logic [WD_W-1:0]    wd_q;
  logic [WD_W-1:0]    wd_inc;
  logic               timeout_hit;
  logic               xfer_end;
  logic               arb_go;
  logic               win_found;
  logic [PTR_W-1:0]   win_idx;
  logic [NUM_REQ-1:0] win_onehot;
  logic [PTR_W-1:0]   ptr_after_owner;
  int unsigned        cand;

  // Rotating scan: first requester at or above the pointer, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = 32'(ptr_q) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!win_found && i_Req[cand[PTR_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(cand);
      end
    end
  end

  always_comb begin
    win_onehot          = '0;
    win_onehot[win_idx] = 1'b1;
  end

  assign arb_go          = win_found && !i_TX_Active;
  assign ptr_after_owner = (owner_q == PTR_MAX) ? '0 : owner_q + 1'b1;

  // Abort decided on the cycle whose increment would bring the watchdog to
  // TIMEOUT_CLKS-1, so ack/timeout land TIMEOUT_CLKS cycles after SEND.
  assign wd_inc      = wd_q + WD_W'(1);
  assign timeout_hit = (wd_inc == WD_LAST);
  assign xfer_end    = i_TX_Done || timeout_hit;

  always_ff @(posedge i_Clock or posedge i_Rst) begin
    if (i_Rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (arb_go) state_d = SEND;
      SEND:      state_d = WAIT_DONE;
      WAIT_DONE: if (xfer_end) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    o_TX_DV = (state_q == SEND);
    o_Busy  = (state_q != IDLE);
  end

  always_ff @(posedge i_Clock or posedge i_Rst) begin
    if (i_Rst) begin
      ptr_q     <= '0;
      owner_q   <= '0;
      grant_q   <= '0;
      ack_q     <= '0;
      timeout_q <= 1'b0;
      byte_q    <= '0;
      wd_q      <= '0;
    end else begin
      ack_q     <= '0;
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (arb_go) begin
            grant_q <= win_onehot;
            owner_q <= win_idx;
            byte_q  <= i_Req_Byte[{win_idx, 3'b000} +: 8];
          end
        end
        SEND: wd_q <= '0;
        WAIT_DONE: begin
          if (wd_q != '1) wd_q <= wd_inc;
          if (xfer_end) begin
            ack_q     <= grant_q;
            timeout_q <= !i_TX_Done;
            grant_q   <= '0;
            ptr_q     <= ptr_after_owner;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_Grant   = grant_q;
  assign o_Ack     = ack_q;
  assign o_Timeout = timeout_q;
  assign o_TX_Byte = byte_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: vector table of arbitration cases
// plus hand sequences for timeout, busy line and mid-transfer reset.
module tb_uart_tx_arbiter;

  localparam int unsigned NUM_REQ      = 4;
  localparam int unsigned TIMEOUT_CLKS = 64;

  logic                 clk = 1'b0;
  logic                 i_Rst;
  logic [NUM_REQ-1:0]   i_Req;
  logic [8*NUM_REQ-1:0] i_Req_Byte;
  logic [NUM_REQ-1:0]   o_Grant;
  logic [NUM_REQ-1:0]   o_Ack;
  logic                 o_Timeout;
  logic                 o_Busy;
  logic                 o_TX_DV;
  logic [7:0]           o_TX_Byte;
  logic                 i_TX_Active;
  logic                 i_TX_Done;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .TIMEOUT_CLKS (TIMEOUT_CLKS)
  ) dut (
    .i_Clock     (clk),
    .i_Rst       (i_Rst),
    .i_Req       (i_Req),
    .i_Req_Byte  (i_Req_Byte),
    .o_Grant     (o_Grant),
    .o_Ack       (o_Ack),
    .o_Timeout   (o_Timeout),
    .o_Busy      (o_Busy),
    .o_TX_DV     (o_TX_DV),
    .o_TX_Byte   (o_TX_Byte),
    .i_TX_Active (i_TX_Active),
    .i_TX_Done   (i_TX_Done)
  );

  typedef struct {
    logic [3:0]  req;
    logic [31:0] bytes;
    logic [3:0]  exp_grant;
    logic [7:0]  exp_byte;
  } vec_t;

  typedef struct {
    logic [3:0] grant;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[12];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sb_push(input logic [3:0] grant, input logic [7:0] data);
    exp_t e;
    e.grant = grant;
    e.data  = data;
    sb.push_back(e);
  endtask

  task automatic wait_dv(input int budget, output int ticks);
    ticks = 0;
    while (o_TX_DV !== 1'b1 && ticks < budget) begin
      tick();
      ticks++;
    end
    check("dv_seen", 32'(o_TX_DV), 32'd1);
  endtask

  task automatic sb_check_dv();
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL sb_empty: got o_TX_DV=1 expected no frame pending");
    end else begin
      e = sb.pop_front();
      check("grant", 32'(o_Grant), 32'(e.grant));
      check("tx_byte", 32'(o_TX_Byte), 32'(e.data));
    end
  endtask

  // Called on the SEND cycle; models the UART and completes with a done pulse.
  task automatic finish_xfer(input logic [3:0] grant, input logic [7:0] data, input int done_delay);
    i_TX_Active = 1'b1;
    i_Req_Byte  = ~i_Req_Byte;
    tick();
    check("dv_one_cycle", 32'(o_TX_DV), 32'd0);
    check("busy_wait", 32'(o_Busy), 32'd1);
    repeat (done_delay) tick();
    i_TX_Done = 1'b1;
    tick();
    i_TX_Done   = 1'b0;
    i_TX_Active = 1'b0;
    check("ack", 32'(o_Ack), 32'(grant));
    check("no_timeout", 32'(o_Timeout), 32'd0);
    check("grant_cleared", 32'(o_Grant), 32'd0);
    check("byte_held", 32'(o_TX_Byte), 32'(data));
  endtask

  initial begin
    int   t;
    int   k;
    logic seen;

    tbl[0]  = '{4'b1111, 32'h13121110, 4'b0001, 8'h10};
    tbl[1]  = '{4'b1111, 32'h13121110, 4'b0010, 8'h11};
    tbl[2]  = '{4'b1111, 32'h13121110, 4'b0100, 8'h12};
    tbl[3]  = '{4'b1111, 32'h13121110, 4'b1000, 8'h13};
    tbl[4]  = '{4'b1111, 32'h13121110, 4'b0001, 8'h10};
    tbl[5]  = '{4'b1000, 32'hB3B2B1B0, 4'b1000, 8'hB3};
    tbl[6]  = '{4'b1001, 32'hB3B2B1B0, 4'b0001, 8'hB0};
    tbl[7]  = '{4'b1000, 32'hB3B2B1B0, 4'b1000, 8'hB3};
    tbl[8]  = '{4'b0100, 32'h00A50000, 4'b0100, 8'hA5};
    tbl[9]  = '{4'b0110, 32'hC3C2C1C0, 4'b0010, 8'hC1};
    tbl[10] = '{4'b0101, 32'hC3C2C1C0, 4'b0100, 8'hC2};
    tbl[11] = '{4'b0011, 32'hC3C2C1C0, 4'b0001, 8'hC0};

    i_Rst       = 1'b0;
    i_Req       = '0;
    i_Req_Byte  = '0;
    i_TX_Active = 1'b0;
    i_TX_Done   = 1'b0;
    #2 i_Rst = 1'b1;
    tick();
    tick();
    check("rst_grant", 32'(o_Grant), 32'd0);
    check("rst_ack", 32'(o_Ack), 32'd0);
    check("rst_timeout", 32'(o_Timeout), 32'd0);
    check("rst_busy", 32'(o_Busy), 32'd0);
    check("rst_dv", 32'(o_TX_DV), 32'd0);
    check("rst_byte", 32'(o_TX_Byte), 32'd0);
    i_Rst = 1'b0;
    tick();

    // Arbitration table: each request applied on the ack cycle of the previous one.
    for (int v = 0; v < 12; v++) begin
      i_Req      = tbl[v].req;
      i_Req_Byte = tbl[v].bytes;
      sb_push(tbl[v].exp_grant, tbl[v].exp_byte);
      wait_dv(20, t);
      check("req_to_dv_latency", 32'(t), 32'd1);
      sb_check_dv();
      finish_xfer(tbl[v].exp_grant, tbl[v].exp_byte, 3);
    end
    i_Req = '0;

    // Spurious done while idle.
    i_TX_Done = 1'b1;
    tick();
    i_TX_Done = 1'b0;
    tick();
    check("idle_done_ack", 32'(o_Ack), 32'd0);
    check("idle_done_busy", 32'(o_Busy), 32'd0);

    // Watchdog abort; requester drops its request mid-transfer, done in SEND ignored.
    i_Req      = 4'b0010;
    i_Req_Byte = 32'h00005A00;
    sb_push(4'b0010, 8'h5A);
    wait_dv(20, t);
    sb_check_dv();
    i_Req       = '0;
    i_TX_Active = 1'b1;
    i_TX_Done   = 1'b1;
    tick();
    i_TX_Done = 1'b0;
    k = 1;
    while (o_Ack == '0 && k < 200) begin
      tick();
      k++;
    end
    check("timeout_latency", 32'(k), 32'd64);
    check("timeout_ack", 32'(o_Ack), 32'b0010);
    check("timeout_flag", 32'(o_Timeout), 32'd1);
    tick();
    check("timeout_pulse_ack", 32'(o_Ack), 32'd0);
    check("timeout_pulse_flag", 32'(o_Timeout), 32'd0);
    i_TX_Active = 1'b0;

    // Pointer advanced past requester 1 despite the abort.
    i_Req      = 4'b0110;
    i_Req_Byte = 32'h00E2E100;
    sb_push(4'b0100, 8'hE2);
    wait_dv(20, t);
    sb_check_dv();
    i_Req = '0;
    finish_xfer(4'b0100, 8'hE2, 2);

    // Done on the same cycle the watchdog would fire: done wins.
    i_Req      = 4'b1000;
    i_Req_Byte = 32'hF3000000;
    sb_push(4'b1000, 8'hF3);
    wait_dv(20, t);
    sb_check_dv();
    i_Req       = '0;
    i_TX_Active = 1'b1;
    seen        = 1'b0;
    repeat (63) begin
      tick();
      seen = seen | (|o_Ack);
    end
    check("coincide_no_early_ack", 32'(seen), 32'd0);
    i_TX_Done = 1'b1;
    tick();
    i_TX_Done   = 1'b0;
    i_TX_Active = 1'b0;
    check("coincide_ack", 32'(o_Ack), 32'b1000);
    check("coincide_no_timeout", 32'(o_Timeout), 32'd0);

    // Busy line held by the transmitter blocks arbitration.
    i_TX_Active = 1'b1;
    i_Req       = 4'b0001;
    i_Req_Byte  = 32'h00000077;
    seen        = 1'b0;
    repeat (5) begin
      tick();
      seen = seen | o_TX_DV;
    end
    check("active_blocks_dv", 32'(seen), 32'd0);
    check("active_idle_busy", 32'(o_Busy), 32'd0);
    i_TX_Active = 1'b0;
    sb_push(4'b0001, 8'h77);
    wait_dv(20, t);
    check("active_release_latency", 32'(t), 32'd1);
    sb_check_dv();
    i_Req = '0;
    finish_xfer(4'b0001, 8'h77, 2);

    // Reset during WAIT_DONE: async clear, no ack, pointer back to 0.
    i_Req      = 4'b0100;
    i_Req_Byte = 32'h00990000;
    sb_push(4'b0100, 8'h99);
    wait_dv(20, t);
    sb_check_dv();
    i_TX_Active = 1'b1;
    tick();
    tick();
    i_Rst = 1'b1;
    #1;
    check("mid_rst_grant", 32'(o_Grant), 32'd0);
    check("mid_rst_busy", 32'(o_Busy), 32'd0);
    check("mid_rst_byte", 32'(o_TX_Byte), 32'd0);
    check("mid_rst_ack", 32'(o_Ack), 32'd0);
    i_Req       = '0;
    i_TX_Active = 1'b0;
    tick();
    i_Rst = 1'b0;
    seen  = 1'b0;
    repeat (4) begin
      tick();
      seen = seen | (|o_Ack) | o_Timeout;
    end
    check("mid_rst_no_ack", 32'(seen), 32'd0);
    i_Req      = 4'b1111;
    i_Req_Byte = 32'h44332211;
    sb_push(4'b0001, 8'h11);
    wait_dv(20, t);
    sb_check_dv();
    i_Req = '0;
    finish_xfer(4'b0001, 8'h11, 2);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
